// File: rtl/serial_pattern_matcher_if.sv
// serial_pattern_matcher_if: control, stream and status bundle of the serial pattern matcher
interface serial_pattern_matcher_if #(parameter int PAT_LEN = 4, parameter int CNT_W = 8);
  logic               enable;
  logic               cfg_we;
  logic [PAT_LEN-1:0] cfg_pattern;
  logic [PAT_LEN-1:0] cfg_mask;
  logic               cfg_overlap;
  logic               data_valid;
  logic               data_in;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic [1:0]         state;
  modport master (
    output enable, cfg_we, cfg_pattern, cfg_mask, cfg_overlap, data_valid, data_in, cnt_clr,
    input  match, match_count, state
  );
  modport slave (
    input  enable, cfg_we, cfg_pattern, cfg_mask, cfg_overlap, data_valid, data_in, cnt_clr,
    output match, match_count, state
  );
endinterface

// File: rtl/serial_pattern_matcher.sv
// serial_pattern_matcher: masked, programmable serial pattern detector with saturating match counter
module serial_pattern_matcher #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input logic                clk,
  input logic                rst,
  serial_pattern_matcher_if.slave bus
);
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, HUNT = 2'd2} state_t;
  state_t             st, st_n;
  logic [PAT_LEN-1:0] pat, pat_n, msk, msk_n, hist, hist_n, shifted;
  logic               ovl, ovl_n, accept, hit, match;
  logic [FW-1:0]      fill, fill_n, fill_inc;
  logic [CNT_W-1:0]   cnt, cnt_n;
  assign shifted  = {hist[PAT_LEN-2:0], bus.data_in};
  assign fill_inc = fill == FULL ? FULL : fill + 1'b1;
  assign accept   = bus.enable && bus.data_valid && !bus.cfg_we && st != IDLE;
  assign hit      = accept && fill_inc == FULL && ((shifted ^ pat) & msk) == '0;
  always_comb begin
    st_n   = st;
    pat_n  = pat;
    msk_n  = msk;
    ovl_n  = ovl;
    hist_n = hist;
    fill_n = fill;
    if (bus.cfg_we) begin
      pat_n  = bus.cfg_pattern;
      msk_n  = bus.cfg_mask;
      ovl_n  = bus.cfg_overlap;
      hist_n = '0;
      fill_n = '0;
      st_n   = bus.enable ? FILL : IDLE;
    end else if (!bus.enable) begin
      hist_n = '0;
      fill_n = '0;
      st_n   = IDLE;
    end else if (st == IDLE) begin
      st_n = FILL;
    end else if (hit && !ovl) begin
      // non-overlap hit: the next match must be built entirely from fresh bits
      hist_n = '0;
      fill_n = '0;
      st_n   = FILL;
    end else if (accept) begin
      hist_n = shifted;
      fill_n = fill_inc;
      st_n   = fill_inc == FULL ? HUNT : FILL;
    end
    cnt_n = bus.cnt_clr ? CNT_W'(hit) : cnt + CNT_W'(hit && cnt != '1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      pat   <= '1;
      msk   <= '1;
      ovl   <= 1'b1;
      hist  <= '0;
      fill  <= '0;
      cnt   <= '0;
      match <= 1'b0;
    end else begin
      st    <= st_n;
      pat   <= pat_n;
      msk   <= msk_n;
      ovl   <= ovl_n;
      hist  <= hist_n;
      fill  <= fill_n;
      cnt   <= cnt_n;
      match <= hit;
    end
  end
  assign bus.match       = match;
  assign bus.match_count = cnt;
  assign bus.state       = st;
endmodule

// File: tb/tb_serial_pattern_matcher.sv
// tb_serial_pattern_matcher: directed plus random stream checked against a bit-queue reference model
module tb_serial_pattern_matcher;
  localparam int P    = 4;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  serial_pattern_matcher_if #(.PAT_LEN(P), .CNT_W(CW)) bus();
  serial_pattern_matcher #(.PAT_LEN(P), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  bit run = 0;
  bit win[$];
  logic [P-1:0] mp = '1, mm = '1;
  bit mo = 1;
  int ecnt = 0, em = 0, es = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  function automatic bit window_hit();
    for (int k = 0; k < P; k++)
      if (mm[k] && win[win.size() - 1 - k] != mp[k]) return 0;
    return 1;
  endfunction
  task automatic tick(input string tag);
    bit hit;
    hit = 0;
    if (rst) begin
      run = 0; win.delete(); mp = '1; mm = '1; mo = 1; ecnt = 0;
    end else begin
      if (bus.cfg_we) begin
        mp = bus.cfg_pattern; mm = bus.cfg_mask; mo = bus.cfg_overlap;
        win.delete(); run = bus.enable;
      end else if (!bus.enable) begin
        run = 0; win.delete();
      end else if (!run) begin
        run = 1;
      end else if (bus.data_valid) begin
        win.push_back(bus.data_in);
        if (win.size() > P) win.delete(0);
        if (win.size() == P && window_hit()) begin
          hit = 1;
          if (!mo) win.delete();
        end
      end
      ecnt = bus.cnt_clr ? int'(hit) : (hit && ecnt < MAXC ? ecnt + 1 : ecnt);
    end
    em = hit;
    es = !run ? 0 : (win.size() < P ? 1 : 2);
    @(posedge clk);
    #1;
    chk({tag, ".match"}, 32'(bus.match), 32'(em));
    chk({tag, ".count"}, 32'(bus.match_count), 32'(ecnt));
    chk({tag, ".state"}, 32'(bus.state), 32'(es));
  endtask
  task automatic idle_inputs();
    bus.cfg_we = 0; bus.data_valid = 0; bus.data_in = 0; bus.cnt_clr = 0;
  endtask
  task automatic bit_in(input string tag, input bit b);
    idle_inputs();
    bus.data_valid = 1; bus.data_in = b;
    tick(tag);
  endtask
  task automatic stream(input string tag, input int n, input logic [15:0] bits);
    for (int i = n - 1; i >= 0; i--) bit_in(tag, bits[i]);
  endtask
  task automatic cfg(input string tag, input logic [P-1:0] p, input logic [P-1:0] m, input bit o);
    idle_inputs();
    bus.cfg_we = 1; bus.cfg_pattern = p; bus.cfg_mask = m; bus.cfg_overlap = o;
    tick(tag);
    bus.cfg_we = 0;
  endtask
  task automatic clr(input string tag);
    idle_inputs();
    bus.cnt_clr = 1;
    tick(tag);
    bus.cnt_clr = 0;
  endtask
  initial begin
    bus.enable = 0; bus.cfg_pattern = '0; bus.cfg_mask = '0; bus.cfg_overlap = 0;
    idle_inputs();
    tick("reset");
    rst = 0;
    bus.enable = 1;
    cfg("t1cfg", 4'b1011, 4'b1111, 1);
    stream("t1", 7, 16'b1011011);
    chk("t1.final_count", 32'(bus.match_count), 32'd2);
    chk("t1.final_state", 32'(bus.state), 32'd2);
    clr("t2clr");
    cfg("t2cfg", 4'b1011, 4'b1111, 0);
    stream("t2", 7, 16'b1011011);
    chk("t2.final_count", 32'(bus.match_count), 32'd1);
    chk("t2.final_state", 32'(bus.state), 32'd1);
    clr("t3clr");
    cfg("t3cfg", 4'b1001, 4'b1001, 1);
    stream("t3", 8, 16'b11010001);
    chk("t3.final_count", 32'(bus.match_count), 32'd1);
    clr("t4clr");
    cfg("t4cfg", 4'b1111, 4'b1111, 1);
    stream("t4", 8, 16'hff);
    chk("t4.saturated", 32'(bus.match_count), 32'd3);
    bus.cnt_clr = 1; bus.data_valid = 1; bus.data_in = 1;
    tick("t4clrhit");
    chk("t4.clr_with_hit", 32'(bus.match_count), 32'd1);
    clr("t5clr");
    cfg("t5cfg", 4'b1011, 4'b1111, 1);
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] v;
      v = 4'b1011;
      bit_in("t5bit", v[i]);
      if (i != 0) for (int j = 0; j < 3; j++) begin idle_inputs(); tick("t5bub"); end
    end
    chk("t5.bubbled_count", 32'(bus.match_count), 32'd1);
    stream("t5a", 3, 16'b101);
    bus.cfg_we = 1; bus.data_valid = 1; bus.data_in = 1;
    tick("t5cfgdrop");
    stream("t5b", 4, 16'b1011);
    chk("t5.after_cfg_count", 32'(bus.match_count), 32'd2);
    stream("t6a", 3, 16'b101);
    rst = 1; bus.data_valid = 1; bus.data_in = 1;
    tick("t6rst");
    chk("t6.rst_state", 32'(bus.state), 32'd0);
    rst = 0;
    cfg("t6cfg", 4'b1011, 4'b1111, 1);
    stream("t6b", 2, 16'b10);
    bus.enable = 0; bus.data_valid = 1; bus.data_in = 1;
    tick("t6dis");
    bus.enable = 1;
    idle_inputs();
    tick("t6reen");
    stream("t6c", 2, 16'b11);
    chk("t6.no_stale_match", 32'(bus.match_count), 32'd0);
    stream("t6d", 4, 16'b1011);
    for (int n = 0; n < 600; n++) begin
      bus.enable     = $urandom_range(0, 19) != 0;
      bus.data_valid = $urandom_range(0, 3) != 0;
      bus.data_in    = $urandom_range(0, 1);
      bus.cnt_clr    = $urandom_range(0, 24) == 0;
      bus.cfg_we     = $urandom_range(0, 39) == 0;
      bus.cfg_pattern = P'($urandom);
      bus.cfg_mask    = P'($urandom);
      bus.cfg_overlap = $urandom_range(0, 1);
      rst = $urandom_range(0, 149) == 0;
      tick("rand");
    end
    rst = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
